// File: rtl/tag_lookup_ctrl.sv
// rtl/tag_lookup_ctrl.sv - direct-mapped tag lookup front-end with miss refill and replay
// Optional hit/miss counters enabled by defining TAG_CTRL_STATS_EN.
module tag_lookup_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 5,
  parameter int TAG_W    = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [ADDR_W-1:0]   resp_addr,
  output logic                refill_req_valid,
  input  logic                refill_req_ready,
  output logic [ADDR_W-1:0]   refill_req_addr,
  input  logic                refill_done,
  output logic [INDEX_W-1:0]  tag_raddr,
  output logic                tag_r_en,
  input  logic [TAG_W-1:0]    tag_rdata,
  output logic [INDEX_W-1:0]  tag_waddr,
  output logic                tag_w_en,
  output logic [TAG_W-1:0]    tag_wdata,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int LINES = 1 << INDEX_W;

  if (TAG_W != ADDR_W - INDEX_W - OFFSET_W) begin : g_bad_tag_w
    $error("TAG_W must equal ADDR_W-INDEX_W-OFFSET_W");
  end

  typedef enum logic [2:0] {RUN, MISS_REQ, MISS_WAIT, FILL, REPLAY} state_t;

  state_t              state;
  logic                b_valid;
  logic [ADDR_W-1:0]   b_addr;
  logic [ADDR_W-1:0]   miss_addr;
  logic                replay_valid;
  logic [ADDR_W-1:0]   replay_addr;
  logic [LINES-1:0]    line_valid;

  logic                accept;
  logic                hit;
  logic [INDEX_W-1:0]  req_index;
  logic [INDEX_W-1:0]  b_index;
  logic [INDEX_W-1:0]  miss_index;
  logic [INDEX_W-1:0]  replay_index;
  logic [TAG_W-1:0]    b_tag;
  logic [TAG_W-1:0]    miss_tag;

  assign req_index    = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign b_index      = b_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign miss_index   = miss_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign replay_index = replay_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign b_tag        = b_addr[ADDR_W-1:ADDR_W-TAG_W];
  assign miss_tag     = miss_addr[ADDR_W-1:ADDR_W-TAG_W];

  assign accept   = req_valid && req_ready;
  assign tag_r_en = accept || (state == REPLAY);
  assign hit      = b_valid && line_valid[b_index] && (tag_rdata == b_tag);

  always_comb begin
    tag_raddr = '0;
    if (state == REPLAY) begin
      tag_raddr = replay_index;
    end else if (accept) begin
      tag_raddr = req_index;
    end
  end

  // req_ready is registered so it already reflects a miss detected in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      req_ready        <= 1'b0;
      b_valid          <= 1'b0;
      b_addr           <= '0;
      miss_addr        <= '0;
      replay_valid     <= 1'b0;
      replay_addr      <= '0;
      line_valid       <= '0;
      resp_valid       <= 1'b0;
      resp_hit         <= 1'b0;
      resp_addr        <= '0;
      refill_req_valid <= 1'b0;
      refill_req_addr  <= '0;
      tag_w_en         <= 1'b0;
      tag_waddr        <= '0;
      tag_wdata        <= '0;
    end else begin
      resp_valid <= 1'b0;
      tag_w_en   <= 1'b0;
      case (state)
        RUN: begin
          if (b_valid && !hit) begin
            // The younger request read this cycle saw a stale line; park it for a re-read.
            state            <= MISS_REQ;
            req_ready        <= 1'b0;
            b_valid          <= 1'b0;
            miss_addr        <= b_addr;
            refill_req_valid <= 1'b1;
            refill_req_addr  <= {b_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            replay_valid     <= accept;
            replay_addr      <= req_addr;
          end else begin
            resp_valid <= b_valid;
            resp_hit   <= b_valid;
            if (b_valid) begin
              resp_addr <= b_addr;
            end
            b_valid   <= accept;
            b_addr    <= req_addr;
            req_ready <= 1'b1;
          end
        end
        MISS_REQ: begin
          if (refill_req_ready) begin
            refill_req_valid <= 1'b0;
            state            <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (refill_done) begin
            state     <= FILL;
            tag_w_en  <= 1'b1;
            tag_waddr <= miss_index;
            tag_wdata <= miss_tag;
          end
        end
        FILL: begin
          line_valid[miss_index] <= 1'b1;
          resp_valid             <= 1'b1;
          resp_hit               <= 1'b0;
          resp_addr              <= miss_addr;
          state                  <= replay_valid ? REPLAY : RUN;
          req_ready              <= !replay_valid;
        end
        REPLAY: begin
          state        <= RUN;
          b_valid      <= 1'b1;
          b_addr       <= replay_addr;
          replay_valid <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef TAG_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_valid) begin
      if (resp_hit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (!resp_hit && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb/tb_tag_lookup_ctrl.sv - randomized bench for tag_lookup_ctrl against a sequential cache model
module tb_tag_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_addr;
  logic        refill_req_valid;
  logic        refill_req_ready = 1'b0;
  logic [31:0] refill_req_addr;
  logic        refill_done = 1'b0;
  logic [7:0]  tag_raddr;
  logic        tag_r_en;
  logic [18:0] tag_rdata = '0;
  logic [7:0]  tag_waddr;
  logic        tag_w_en;
  logic [18:0] tag_wdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  tag_lookup_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_addr(resp_addr),
    .refill_req_valid(refill_req_valid), .refill_req_ready(refill_req_ready),
    .refill_req_addr(refill_req_addr), .refill_done(refill_done),
    .tag_raddr(tag_raddr), .tag_r_en(tag_r_en), .tag_rdata(tag_rdata),
    .tag_waddr(tag_waddr), .tag_w_en(tag_w_en), .tag_wdata(tag_wdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  logic [18:0] tram [256];
  always @(posedge clk) begin
    if (tag_r_en) tag_rdata <= tram[tag_raddr];
    if (tag_w_en) tram[tag_waddr] <= tag_wdata;
  end

  typedef struct { logic [31:0] addr; logic hit; int cyc; logic fast; } exp_t;
  typedef struct { logic [31:0] addr; logic hit; int cyc; } rsp_t;

  exp_t        exp_q[$];
  rsp_t        rsp_log[$];
  logic [31:0] refill_q[$];
  logic [31:0] rf_log[$];
  logic [31:0] tw_log[$];
  logic        m_valid [256];
  logic [18:0] m_tag [256];
  exp_t        ce;
  int          total = 0;
  int          bad = 0;
  int          ncyc = 0;
  int          m_hits = 0;
  int          m_misses = 0;
  logic [31:0] fill_line = '0;
  logic [31:0] prev_ra = '0;
  logic        prev_rv = 1'b0;
  logic        prev_hs = 1'b0;
  int          phase = 0;
  int          delay = 0;
  bit          started = 1'b0;
  bit          bp_force = 1'b0;
  bit          hold_done = 1'b0;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] outs_or();
    return resp_addr | refill_req_addr | hit_count | miss_count | {13'b0, tag_wdata} |
           {24'b0, tag_waddr} | {24'b0, tag_raddr} |
           {26'b0, resp_valid, resp_hit, req_ready, refill_req_valid, tag_r_en, tag_w_en};
  endfunction

  function automatic logic [32:0] rsp_at(input int i);
    if (i < rsp_log.size()) return {rsp_log[i].hit, rsp_log[i].addr};
    return '1;
  endfunction

  function automatic int rsp_cyc(input int i);
    if (i < rsp_log.size()) return rsp_log[i].cyc;
    return -1;
  endfunction

  function automatic logic [31:0] rf_at(input int i);
    if (i < rf_log.size()) return rf_log[i];
    return '1;
  endfunction

  function automatic logic [31:0] tw_at(input int i);
    if (i < tw_log.size()) return tw_log[i];
    return '1;
  endfunction

  // Requests are resolved strictly in acceptance order; a miss installs its line before the next one is looked up.
  task automatic model_accept(input logic [31:0] a);
    exp_t        e;
    logic [7:0]  ix;
    logic [18:0] tg;
    bit          pend;
    ix = a[12:5];
    tg = a[31:13];
    pend = 1'b0;
    foreach (exp_q[i]) if (!exp_q[i].hit) pend = 1'b1;
    e.addr = a;
    e.hit  = m_valid[ix] && (m_tag[ix] == tg);
    e.cyc  = ncyc;
    e.fast = e.hit && !pend;
    if (!e.hit) begin
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tg;
      refill_q.push_back({a[31:5], 5'b0});
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      exp_q.delete();
      refill_q.delete();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_hits = 0;
      m_misses = 0;
      prev_rv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (resp_valid) begin
        rsp_log.push_back('{resp_addr, resp_hit, ncyc});
        if (exp_q.size() == 0) begin
          check(1'b0, "resp_extra", resp_addr, 0);
        end else begin
          ce = exp_q.pop_front();
          check(resp_hit == ce.hit, "resp_hit", resp_hit, ce.hit);
          check(resp_addr == ce.addr, "resp_addr", resp_addr, ce.addr);
          if (ce.fast) check(ncyc == ce.cyc + 2, "hit_latency", ncyc - ce.cyc, 2);
          if (ce.hit) m_hits++; else m_misses++;
        end
      end
      if (refill_req_valid && refill_req_ready) begin
        rf_log.push_back(refill_req_addr);
        if (refill_q.size() == 0) begin
          check(1'b0, "refill_extra", refill_req_addr, 0);
        end else begin
          fill_line = refill_q.pop_front();
          check(refill_req_addr == fill_line, "refill_addr", refill_req_addr, fill_line);
        end
      end
      if (tag_w_en) begin
        tw_log.push_back({5'b0, tag_wdata, tag_waddr});
        check({tag_wdata, tag_waddr} == {fill_line[31:13], fill_line[12:5]}, "tag_write",
              {tag_wdata, tag_waddr}, {fill_line[31:13], fill_line[12:5]});
      end
      if (prev_rv && !prev_hs)
        check(refill_req_valid && (refill_req_addr == prev_ra), "refill_hold", {refill_req_valid, refill_req_addr}, {1'b1, prev_ra});
      if (refill_req_valid)
        check(!req_ready && !tag_w_en, "stall", {req_ready, tag_w_en}, 0);
      prev_rv = refill_req_valid;
      prev_hs = refill_req_valid && refill_req_ready;
      prev_ra = refill_req_addr;
      if (req_valid && req_ready) model_accept(req_addr);
    end
  end

  // Refill agent: random accept/done latencies, plus stray pulses whenever no refill is due.
  initial begin
    forever begin
      @(posedge clk); #1;
      refill_req_ready = 1'b0;
      refill_done = 1'b0;
      if (!rst_n) begin
        phase = 0;
        started = 1'b0;
      end else if (phase == 0) begin
        if (refill_req_valid) begin
          if (!started) begin
            started = 1'b1;
            delay = bp_force ? 5 : int'($urandom_range(0, 3));
          end
          if (delay == 0) begin
            refill_req_ready = 1'b1;
            phase = 1;
            started = 1'b0;
            delay = $urandom_range(0, 4);
          end else begin
            delay--;
            if ($urandom_range(0, 3) == 0) refill_done = 1'b1;
          end
        end else begin
          if ($urandom_range(0, 7) == 0) refill_done = 1'b1;
          if ($urandom_range(0, 7) == 0) refill_req_ready = 1'b1;
        end
      end else if (!hold_done) begin
        if (delay == 0) begin
          refill_done = 1'b1;
          phase = 0;
        end else begin
          delay--;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a);
    int t = 0;
    req_valid = 1'b1;
    req_addr = a;
    while (!req_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) check(1'b0, "req_ready_timeout", t, 300);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check(exp_q.size() == 0, "drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int r0, f0, w0, a0, t;
    logic [18:0] tg;
    logic [31:0] a;
    logic [31:0] exp_h, exp_m;
    foreach (tram[i]) tram[i] = 19'($urandom);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(outs_or() == 0, "reset_outputs", outs_or(), 0);
    rst_n = 1'b1;

    // cold miss on index 1
    r0 = rsp_log.size(); f0 = rf_log.size(); w0 = tw_log.size();
    send(32'h0000_0020);
    drain();
    check(rsp_at(r0) == {1'b0, 32'h20}, "cold_resp", rsp_at(r0), {1'b0, 32'h20});
    check(rf_at(f0) == 32'h20, "cold_refill_addr", rf_at(f0), 32'h20);
    check(tw_at(w0) == 32'h0000_0001, "cold_tag_write", tw_at(w0), 32'h1);

    // back-to-back hits
    r0 = rsp_log.size(); f0 = rf_log.size();
    send(32'h0000_0020);
    a0 = ncyc;
    send(32'h0000_0024);
    drain();
    check(rsp_at(r0) == {1'b1, 32'h20}, "hit0_resp", rsp_at(r0), {1'b1, 32'h20});
    check(rsp_at(r0 + 1) == {1'b1, 32'h24}, "hit1_resp", rsp_at(r0 + 1), {1'b1, 32'h24});
    check(rsp_cyc(r0) == a0 + 2, "hit0_cycle", rsp_cyc(r0), a0 + 2);
    check(rsp_cyc(r0 + 1) == a0 + 3, "hit1_cycle", rsp_cyc(r0 + 1), a0 + 3);
    check(rf_log.size() == f0, "hit_no_refill", rf_log.size(), f0);

    // conflict miss with a replayed younger request
    r0 = rsp_log.size(); f0 = rf_log.size(); w0 = tw_log.size();
    send(32'h0000_2020);
    send(32'h0000_0040);
    drain();
    check(rf_at(f0) == 32'h2020, "conf_refill0", rf_at(f0), 32'h2020);
    check(rf_at(f0 + 1) == 32'h40, "conf_refill1", rf_at(f0 + 1), 32'h40);
    check(tw_at(w0) == 32'h0000_0101, "conf_tag_write", tw_at(w0), 32'h101);
    check(rsp_at(r0) == {1'b0, 32'h2020}, "conf_resp0", rsp_at(r0), {1'b0, 32'h2020});
    check(rsp_at(r0 + 1) == {1'b0, 32'h40}, "conf_resp1", rsp_at(r0 + 1), {1'b0, 32'h40});

    // refill backpressure for 5 cycles
    bp_force = 1'b1;
    send(32'h0000_0060);
    t = 0;
    while (!refill_req_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check(refill_req_valid, "bp_wait", refill_req_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check({refill_req_valid, req_ready, tag_w_en, refill_req_addr} == {3'b100, 32'h60}, "bp_hold",
            {refill_req_valid, req_ready, tag_w_en, refill_req_addr}, {3'b100, 32'h60});
      @(posedge clk); #1;
    end
    bp_force = 1'b0;
    drain();

    // reset while waiting for refill_done
    hold_done = 1'b1;
    send(32'h0000_0080);
    t = 0;
    while (phase != 1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check(phase == 1, "rst_reach_wait", phase, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check(outs_or() == 0, "rst_midrefill_outputs", outs_or(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_done = 1'b0;

    // after reset: 2 misses and 3 hits
    r0 = rsp_log.size();
    send(32'h0000_0020);
    send(32'h0000_0020);
    send(32'h0000_0024);
    send(32'h0000_0028);
    send(32'h0000_0100);
    drain();
    check(rsp_at(r0) == {1'b0, 32'h20}, "post_rst_miss", rsp_at(r0), {1'b0, 32'h20});
    check(rsp_at(r0 + 1) == {1'b1, 32'h20}, "replay_hit", rsp_at(r0 + 1), {1'b1, 32'h20});
`ifdef TAG_CTRL_STATS_EN
    exp_h = 32'd3; exp_m = 32'd2;
`else
    exp_h = 32'd0; exp_m = 32'd0;
`endif
    check(hit_count == exp_h, "stats_hits", hit_count, exp_h);
    check(miss_count == exp_m, "stats_misses", miss_count, exp_m);

    // randomized traffic over a small set of lines and tags
    for (int n = 0; n < 300; n++) begin
      tg = ($urandom_range(0, 9) == 0) ? 19'($urandom) : 19'($urandom_range(0, 3));
      a = {tg, 8'($urandom_range(0, 7)), 5'($urandom)};
      send(a);
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    drain();
`ifdef TAG_CTRL_STATS_EN
    exp_h = 32'(m_hits); exp_m = 32'(m_misses);
`else
    exp_h = 32'd0; exp_m = 32'd0;
`endif
    check(hit_count == exp_h, "final_hits", hit_count, exp_h);
    check(miss_count == exp_m, "final_misses", miss_count, exp_m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tag_lookup_ctrl.md
Name: tag_lookup_ctrl

Overview:
- Direct-mapped cache front-end stage that sits directly upstream of the tag RAM (8-bit index, 19-bit tag, 1-cycle registered read, separate read/write ports).
- Accepts CPU lookup requests and drives the tag RAM read/write ports.
- Consumes the tag RAM read data, compares it against the request tag and a per-line valid array, and reports hit/miss.
- Sequences line refills over a simple request/done handshake and writes the new tag back to the RAM.

Parameters:
ADDR_W, 32, request byte-address width
INDEX_W, 8, set-index width (256 lines)
OFFSET_W, 5, line-offset width (32-byte lines)
TAG_W, 19, tag width; must equal ADDR_W-INDEX_W-OFFSET_W (elaboration error otherwise)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  lookup request valid
req_ready  output  1  request accepted when req_valid && req_ready at clk edge
req_addr  input  ADDR_W  lookup byte address
resp_valid  output  1  one-cycle response pulse, in acceptance order
resp_hit  output  1  1=hit, 0=miss (miss response issued after refill)
resp_addr  output  ADDR_W  address of the responded request
refill_req_valid  output  1  refill request, held until accepted
refill_req_ready  input  1  refill acceptor ready
refill_req_addr  output  ADDR_W  line-aligned miss address (offset bits zero)
refill_done  input  1  one-cycle pulse: line data written, tag may be installed
tag_raddr  output  INDEX_W  tag RAM read index
tag_r_en  output  1  tag RAM read enable
tag_rdata  input  TAG_W  tag RAM dout, valid the cycle after tag_r_en
tag_waddr  output  INDEX_W  tag RAM write index
tag_w_en  output  1  tag RAM write enable
tag_wdata  output  TAG_W  tag RAM write data
hit_count  output  32  hit counter (see Optional Feature)
miss_count  output  32  miss counter (see Optional Feature)

Behaviour:
- Reset values (async, rst_n low): all outputs 0. FSM goes to RUN, both pipeline stages are empty, and all 256 valid bits are cleared. Reset may be asserted in any state, including mid-refill. An in-flight refill is abandoned; the refill agent is reset by the same rst_n.
- Address split: index = addr[OFFSET_W+INDEX_W-1:OFFSET_W]; tag = addr[ADDR_W-1:ADDR_W-TAG_W].
- Stage A (accept), cycle N: req_ready=1 only in RUN. On accept: tag_r_en=1 and tag_raddr=index, both driven combinationally from req_addr in the same cycle. The address is registered into stage B.
- Stage B (compare), cycle N+1: hit = valid[index] && (tag_rdata == tag).
- Hit: resp_valid=1, resp_hit=1, resp_addr=request address, all registered, visible in cycle N+2. Back-to-back hits sustain one request per cycle.
- Miss in stage B: FSM moves RUN->MISS_REQ and req_ready drops to 0.
  - A younger request accepted in cycle N+1 (already in stage A) is held in a replay register. Its read result is discarded.
- MISS_REQ: refill_req_valid=1, refill_req_addr = line-aligned miss address, held stable until refill_req_ready=1. Then -> MISS_WAIT.
- MISS_WAIT: wait for refill_done. Then -> FILL.
- FILL (1 cycle):
  - tag_w_en=1, tag_waddr=index, tag_wdata=tag.
  - valid[index] set at the clock edge.
  - Miss response registered: resp_valid=1 and resp_hit=0 visible the cycle after FILL.
  - Then -> REPLAY if the replay register is occupied, else -> RUN.
- REPLAY: re-issue the held request (tag_r_en=1) and enter stage B next cycle with req_ready=0. Then -> RUN. The replayed request may itself hit or miss.
- The replayed read is never issued in the same cycle as a tag write, so RAM read-during-write behaviour is never exercised.
- refill_done outside MISS_WAIT is ignored. refill_req_ready outside MISS_REQ is ignored.
- Responses are always returned in acceptance order, with at most one per cycle.

Optional Feature:
- TAG_CTRL_STATS_EN defined:
  - hit_count and miss_count increment on each resp_valid with resp_hit=1 or resp_hit=0 respectively.
  - Both are 32-bit, saturate at 0xFFFF_FFFF, and are cleared by rst_n.
- Not defined: hit_count and miss_count are tied to 0 and no counter flops are synthesised.

Test Plan:
- Cold miss:
  - Stimulus: after reset, request 0x0000_0020.
  - Response: refill_req_addr=0x0000_0020. After refill_done, FILL drives tag_waddr=1, tag_wdata=0. Then resp_valid with resp_hit=0, resp_addr=0x0000_0020.
- Hit latency and throughput:
  - Stimulus: 0x0000_0020 then 0x0000_0024 on consecutive cycles.
  - Response: two resp_hit=1 pulses in cycles N+2 and N+3, with no refill request.
- Conflict miss with replay:
  - Stimulus: with index 1 holding tag 0, request 0x0000_2020 (index 1, tag 1) immediately followed by 0x0000_0040.
  - Response: miss refill for 0x0000_2020 with tag_wdata=1. Then 0x0000_0040 is replayed and misses (refill_req_addr=0x0000_0040). Responses arrive in order.
- Refill backpressure:
  - Stimulus: hold refill_req_ready low for 5 cycles.
  - Response: refill_req_valid and refill_req_addr stay stable, req_ready stays 0, and no tag write occurs.
- Reset in MISS_WAIT:
  - Stimulus: assert rst_n=0 mid-refill, release, then request 0x0000_0020 again.
  - Response: all outputs go to 0 immediately. The new request misses (valid cleared).
- Stats (macro defined):
  - Stimulus: 3 hits and 2 misses.
  - Response: hit_count=3, miss_count=2. Without the macro, both read 0.
